// File: rtl/sa_addr_pkg.sv
// Shared definitions for the skewed SRAM read-address generator:
// sweep FSM encoding and default width constants.
package sa_addr_pkg;

   localparam int DEF_ARRAY_SIZE  = 8;
   localparam int DEF_ADDR_WIDTH  = 10;
   localparam int DEF_CNT_WIDTH   = 10;
   localparam int DEF_ADDR_OFFSET = 4;

   // Sweep control states; explicit encoding keeps waveforms readable.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of weight/data queue pairs serving an array of the given size.
   function automatic int queue_count(input int array_size);
      return (array_size + 3) / 4;
   endfunction

endpackage

// File: rtl/skew_addr_lane.sv
// One queue lane of the skewed address generator. Decides whether the
// lane is live for a given step and forms its weight/data addresses.
// Purely combinational; the top registers the results.
module skew_addr_lane
   import sa_addr_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int                    CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int                    STEP_W      = DEF_CNT_WIDTH + 1,
   parameter int                    LANE_OFFSET = 0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_IDLE   = '1
)(
   input  logic                  en,
   input  logic [STEP_W-1:0]     cnt,
   input  logic [CNT_WIDTH-1:0]  len,
   input  logic [ADDR_WIDTH-1:0] base_w,
   input  logic [ADDR_WIDTH-1:0] base_d,
   output logic                  active,
   output logic [ADDR_WIDTH-1:0] addr_w,
   output logic [ADDR_WIDTH-1:0] addr_d
);

   // One extra bit so start + len cannot overflow the window compare.
   localparam logic [STEP_W:0] LANE_START = (STEP_W + 1)'(LANE_OFFSET);

   logic [STEP_W:0]   cnt_ext;
   logic [STEP_W:0]   lane_stop;
   logic [STEP_W-1:0] offs;

   // Window test [start, start+len) and address = base + steps into window.
   always_comb begin
      // NOTE: every output gets a default before the conditional update so
      // no path leaves a value unassigned and no latch is inferred.
      addr_w    = ADDR_IDLE;
      addr_d    = ADDR_IDLE;
      cnt_ext   = {1'b0, cnt};
      lane_stop = LANE_START + (STEP_W + 1)'(len);
      offs      = cnt - LANE_START[STEP_W-1:0];
      active    = en && (cnt_ext >= LANE_START) && (cnt_ext < lane_stop);
      if (active) begin
         // Truncation to ADDR_WIDTH gives the intended modulo wrap.
         addr_w = base_w + ADDR_WIDTH'(offs);
         addr_d = base_d + ADDR_WIDTH'(offs);
      end
   end

endmodule

// File: rtl/skew_addr_gen.sv
// Skewed SRAM read-address generator for a systolic array. Each queue k
// replays the same len-long address run, delayed by k*ADDR_OFFSET steps.
// All outputs are registered from next-state values, so the addresses for
// step c appear in the same cycle the step counter holds c.
module skew_addr_gen
   import sa_addr_pkg::*;
#(
   parameter int                    ARRAY_SIZE  = DEF_ARRAY_SIZE,
   parameter int                    QUEUE_COUNT = (ARRAY_SIZE + 3) / 4,
   parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int                    CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int                    ADDR_OFFSET = DEF_ADDR_OFFSET,
   parameter logic [ADDR_WIDTH-1:0] ADDR_IDLE   = '1
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              stall,
   input  logic [CNT_WIDTH-1:0]              len,
   input  logic [ADDR_WIDTH-1:0]             base_w,
   input  logic [ADDR_WIDTH-1:0]             base_d,
   output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_raddr_w_packed,
   output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_raddr_d_packed,
   output logic [QUEUE_COUNT-1:0]            addr_valid,
   output logic                              busy,
   output logic                              done
);

   // Skew of the last queue; the step counter must reach skew + len - 1.
   // One bit above CNT_WIDTH covers that sum while the skew fits in CNT_WIDTH.
   localparam int SKEW_MAX = (QUEUE_COUNT - 1) * ADDR_OFFSET;
   localparam int STEP_W   = CNT_WIDTH + 1;

   state_t                  state_q, state_nxt;
   logic [STEP_W-1:0]       cnt_q, cnt_nxt, last_step;
   logic [CNT_WIDTH-1:0]    len_q, len_nxt;
   logic [ADDR_WIDTH-1:0]   bw_q, bw_nxt, bd_q, bd_nxt;
   logic                    run_nxt;

   logic [QUEUE_COUNT*ADDR_WIDTH-1:0] w_nxt, d_nxt;
   logic [QUEUE_COUNT-1:0]            valid_nxt;

   assign last_step = STEP_W'(SKEW_MAX) + STEP_W'(len_q) - STEP_W'(1);
   assign run_nxt   = (state_nxt == RUN);

   // Sweep FSM, step counter and operand capture on the accepting edge.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      len_nxt   = len_q;
      bw_nxt    = bw_q;
      bd_nxt    = bd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_nxt = len;
               bw_nxt  = base_w;
               bd_nxt  = base_d;
               cnt_nxt = '0;
               // An empty sweep skips RUN and only produces the done pulse.
               state_nxt = (len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (!stall) begin
               if (cnt_q == last_step) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt_q + STEP_W'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-queue lanes evaluated on the next-cycle step value.
   for (genvar k = 0; k < QUEUE_COUNT; k++) begin : g_lane
      skew_addr_lane #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .CNT_WIDTH   (CNT_WIDTH),
         .STEP_W      (STEP_W),
         .LANE_OFFSET (k * ADDR_OFFSET),
         .ADDR_IDLE   (ADDR_IDLE)
      ) u_lane (
         .en     (run_nxt),
         .cnt    (cnt_nxt),
         .len    (len_nxt),
         .base_w (bw_nxt),
         .base_d (bd_nxt),
         .active (valid_nxt[k]),
         .addr_w (w_nxt[(k+1)*ADDR_WIDTH-1 -: ADDR_WIDTH]),
         .addr_d (d_nxt[(k+1)*ADDR_WIDTH-1 -: ADDR_WIDTH])
      );
   end

   // State and registered outputs; reset overrides start and stall.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q             <= IDLE;
         cnt_q               <= '0;
         len_q               <= '0;
         bw_q                <= '0;
         bd_q                <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         addr_valid          <= '0;
         sram_raddr_w_packed <= {QUEUE_COUNT{ADDR_IDLE}};
         sram_raddr_d_packed <= {QUEUE_COUNT{ADDR_IDLE}};
      end else begin
         state_q             <= state_nxt;
         cnt_q               <= cnt_nxt;
         len_q               <= len_nxt;
         bw_q                <= bw_nxt;
         bd_q                <= bd_nxt;
         busy                <= run_nxt;
         done                <= (state_nxt == DONE);
         addr_valid          <= valid_nxt;
         sram_raddr_w_packed <= w_nxt;
         sram_raddr_d_packed <= d_nxt;
      end
   end

endmodule
